note_player: RTL and testbench
==============================

# note_player

Playback engine for the guitar recorder: on start it walks the 64×32 note memory from address 0 to a caller-supplied last address, fetching one note word per beat tick. Each word is decoded into per-string fret positions, and each sounding string drives a square-wave tone generator. It sits between the shared `clock_devider` beat tick, the read port of the note RAM and the audio output stage.

## Interface
- `ADDR_W`, 6, note memory address width (64 entries)
- `NOTE_W`, 32, note word width; bits 31:30 unused
- `HP_W`, 19, half-period counter width
- `clk` in 1: system clock, 50 MHz
- `resetn` in 1: reset, synchronous and active-low
- `start` in 1: one-cycle pulse; begins playback, honoured only in IDLE
- `stop` in 1: one-cycle pulse; aborts playback from any state
- `beat` in 1: one-cycle tempo tick from the clock divider
- `last_addr` in ADDR_W: address of the final recorded note; sampled on the accepted `start`
- `rd_en` out 1: memory read strobe
- `rd_addr` out ADDR_W: memory read address
- `rd_data` in NOTE_W: memory read data, valid exactly one cycle after `rd_en`
- `playing` out 1: high in FETCH, LOAD and HOLD
- `done` out 1: one-cycle pulse when the last note's beat ends
- `string_on` out 6: string s sounding in the current note
- `string_fret` out 18: 3 bits per string, `[3s+2:3s]`, values 0–4
- `tone` out 6: per-string square wave
- `mix` out 3: popcount of `tone`, 0–6

## Operation
- FSM states: IDLE, FETCH, LOAD, HOLD, DONE.
- IDLE: when `start`=1, clear the address to 0, latch `last_addr`, and go to FETCH.
- FETCH: `rd_en`=1 for exactly one cycle at the current address, then go to LOAD.
- LOAD: capture `rd_data`, decode it, update `string_on`/`string_fret`, restart all tone generators, then go to HOLD.
- HOLD: hold the note until `beat`.
  - On `beat`, if address == latched last: go to DONE.
  - Otherwise, increment the address and go to FETCH.
- DONE: `done`=1 for one cycle, clear `string_on`, force `tone` to 0, then go to IDLE.
- Decode, per string s (0..5):
  - fret = highest f in 1..4 with `note[6f+s]`=1.
  - Otherwise fret = 0 if `note[s]`=1.
  - Otherwise the string is off, with `string_fret` field = 0.
  - Bits 31:30 are ignored. If several bits are set for one string, the highest fret wins.
- Tone generator per string:
  - While `string_on[s]`, the counter decrements every clk.
  - At 0 the counter reloads `HALF_PERIOD[s][fret]−1` and toggles `tone[s]`.
  - While the string is off: `tone[s]`=0 and the counter is held at the reload value.
  - LOAD reloads the counter and clears the tone for every string.
- Boundaries:
  - `stop` has priority over everything. The next state is IDLE; `string_on`, `tone`, `rd_en` and `playing` are 0 the next cycle; no `done` is issued.
  - `start` outside IDLE is ignored.
  - `start` and `stop` in the same cycle: `stop` wins.
  - `beat` outside HOLD is ignored; it is not queued.
  - `last_addr`=0 plays a single note.
  - `last_addr`=63 plays all entries. The address never wraps past 63.
  - An all-zero note word gives a silent beat, and playback continues.
  - `resetn`=0 mid-playback behaves as `stop`, and all registers return to their reset values.

## Timing
- Reset values:
  - State is IDLE.
  - `rd_en`, `rd_addr`, `playing`, `done`, `string_on`, `string_fret`, `tone` and `mix` are all 0.
  - All counters are 0.
- With `start` accepted at cycle t:
  - t+1: FETCH, with `rd_en`=1 and `rd_addr`=0.
  - t+2: LOAD, capturing `rd_data`.
  - t+3: HOLD, with `string_on`/`string_fret` valid.
- Beat to next note: `beat` at cycle b in HOLD gives FETCH at b+1 and new outputs at b+3.
- The first tone toggle occurs `HALF_PERIOD` cycles after LOAD.
- `mix` is registered and lags `tone` by 1 cycle.
- On the final beat at cycle b: DONE at b+1 with `done`=1, and IDLE at b+2.

## Structure
- Shared package `guitar_pkg`:
  - `NUM_STRINGS`=6, `NUM_FRETS`=5.
  - The state encoding.
  - `HALF_PERIOD[6][5]` constants, with string open-note offsets {0,5,10,15,19,24} semitones above E2 (82.407 Hz).
  - Each constant is HALF_PERIOD = round(50e6 / (2·82.407·2^((off+fret)/12))).
  - Examples: [0][0]=303373, [1][0]=227273.
- The natural sub-module is `tone_gen` (counter, toggle flop, reload), instantiated 6 times.

## Test plan
- Reset and idle: hold `resetn`=0 for 3 cycles, then release with no `start` → all outputs 0, `rd_en` never asserted.
- Single-note handshake:
  - Stimulus: `last_addr`=0, mem[0]=0x0000_0002 (string 1 open), `start`, then `beat` 10 cycles later.
  - Response: `rd_en`/`rd_addr`=0 at t+1, `string_on`=6'b000010 and fret 0 at t+3, `done` 1 cycle after the beat.
- Tone period: mem[0]=0x0000_0001 held across many cycles → `tone[0]` toggles every 303373 cycles; `mix` alternates 0/1.
- Decode priority: mem word with bits 6 and 24 set (string 0, frets 1 and 4) → `string_fret[2:0]`=4; bits 31:30 set alone → all strings off.
- Sequence and wrap:
  - Stimulus: `last_addr`=63, 64 beats.
  - Response: `rd_addr` steps 0..63 once, `done` after the 64th beat, never a read of address 0 after 63.
- Abort and ignored inputs:
  - `stop` in HOLD → IDLE next cycle, tones 0, no `done`.
  - `beat` during FETCH is ignored.
  - `start` during HOLD is ignored.

Source files
------------

// File: rtl/guitar_pkg.sv
// Shared types, constants and helpers for the guitar recorder playback path.
package guitar_pkg;

    localparam int unsigned ADDR_W      = 6;
    localparam int unsigned NOTE_W      = 32;
    localparam int unsigned HP_W        = 19;
    localparam int unsigned NUM_STRINGS = 6;
    localparam int unsigned NUM_FRETS   = 5;
    localparam int unsigned FRET_W      = 3;
    localparam int unsigned MIX_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Decoded note word: which strings sound and at which fret.
    typedef struct packed {
        logic [NUM_STRINGS-1:0]        on;
        logic [NUM_STRINGS*FRET_W-1:0] fret;
    } note_dec_t;

    // Half-period in clk cycles, open strings at {0,5,10,15,19,24} semitones above E2.
    localparam logic [HP_W-1:0] HALF_PERIOD [NUM_STRINGS][NUM_FRETS] = '{
        '{19'd303373, 19'd286346, 19'd270274, 19'd255105, 19'd240787},
        '{19'd227273, 19'd214517, 19'd202477, 19'd191113, 19'd180386},
        '{19'd170262, 19'd160706, 19'd151686, 19'd143173, 19'd135137},
        '{19'd127553, 19'd120394, 19'd113636, 19'd107258, 19'd101238},
        '{19'd101238, 19'd95556,  19'd90193,  19'd85131,  19'd80353 },
        '{19'd75843,  19'd71586,  19'd67569,  19'd63776,  19'd60197 }
    };

    // Bit 6f+s marks fret f on string s; scanning upward lets the highest fret win.
    function automatic note_dec_t note_decode(input logic [NOTE_W-1:0] note);
        note_dec_t d;
        d = '0;
        for (int f = 0; f < int'(NUM_FRETS); f++) begin
            for (int s = 0; s < int'(NUM_STRINGS); s++) begin
                if (note[int'(NUM_STRINGS)*f + s]) begin
                    d.on[s]                    = 1'b1;
                    d.fret[FRET_W*s +: FRET_W] = FRET_W'(f);
                end
            end
        end
        return d;
    endfunction

    // Counter reload value for a string/fret pair; out-of-range frets reload 0.
    function automatic logic [HP_W-1:0] hp_reload(input logic [2:0] s, input logic [2:0] f);
        logic [HP_W-1:0] r;
        r = '0;
        if ((s < 3'(NUM_STRINGS)) && (f < 3'(NUM_FRETS))) begin
            r = HALF_PERIOD[s][f] - HP_W'(1);
        end
        return r;
    endfunction

    // Number of tones currently high.
    function automatic logic [MIX_W-1:0] tone_count(input logic [NUM_STRINGS-1:0] v);
        logic [MIX_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_STRINGS); i++) begin
            c = c + MIX_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator for one string: down-counter with reload and toggle flop.
module tone_gen
    import guitar_pkg::*;
#(
    parameter int unsigned STR = 0
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              on,
    input  logic              restart,
    input  logic [FRET_W-1:0] fret,
    output logic              tone
);

    logic [HP_W-1:0] cnt_q;
    logic [HP_W-1:0] reload_c;

    assign reload_c = hp_reload(3'(STR), fret);

    // Restart or silence parks the counter at its reload value with tone low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            tone  <= 1'b0;
        end else if (restart || !on) begin
            cnt_q <= reload_c;
            tone  <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q <= reload_c;
            tone  <= ~tone;
        end else begin
            cnt_q <= cnt_q - HP_W'(1);
        end
    end

endmodule

// File: rtl/note_player.sv
// Walks note memory one word per beat, decodes strings/frets and drives per-string tones.
module note_player
    import guitar_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          beat,
    input  logic [ADDR_W-1:0]             last_addr,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [NOTE_W-1:0]             rd_data,
    output logic                          playing,
    output logic                          done,
    output logic [NUM_STRINGS-1:0]        string_on,
    output logic [NUM_STRINGS*FRET_W-1:0] string_fret,
    output logic [NUM_STRINGS-1:0]        tone,
    output logic [MIX_W-1:0]              mix
);

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [ADDR_W-1:0]   last_q, last_n;
    note_dec_t           dec_c;
    logic                load_c;
    logic                clr_c;
    logic                restart_c;
    logic [NUM_STRINGS*FRET_W-1:0] gen_fret_c;
    logic                unused_ok;

    assign dec_c     = note_decode(rd_data);
    assign unused_ok = &{1'b0, rd_data[NOTE_W-1:NOTE_W-2]};

    // State and address registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            last_q  <= last_n;
        end
    end

    // Next-state logic; stop overrides every transition.
    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        last_n    = last_q;
        load_c    = 1'b0;
        clr_c     = 1'b0;
        restart_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_FETCH;
                    addr_n  = '0;
                    last_n  = last_addr;
                end
            end
            ST_FETCH: state_n = ST_LOAD;
            ST_LOAD: begin
                state_n = ST_HOLD;
                load_c  = 1'b1;
            end
            ST_HOLD: begin
                if (beat) begin
                    if (addr_q == last_q) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_FETCH;
                        addr_n  = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (stop) begin
            state_n = ST_IDLE;
        end
        clr_c     = stop || (state_n == ST_DONE);
        restart_c = load_c || clr_c;
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            playing     <= 1'b0;
            done        <= 1'b0;
            string_on   <= '0;
            string_fret <= '0;
            mix         <= '0;
        end else begin
            rd_en   <= (state_n == ST_FETCH);
            rd_addr <= addr_n;
            playing <= (state_n == ST_FETCH) || (state_n == ST_LOAD) || (state_n == ST_HOLD);
            done    <= (state_n == ST_DONE);
            mix     <= tone_count(tone);
            if (clr_c) begin
                string_on   <= '0;
                string_fret <= '0;
            end else if (load_c) begin
                string_on   <= dec_c.on;
                string_fret <= dec_c.fret;
            end
        end
    end

    // Generators reload with the incoming note's frets while it is being loaded.
    assign gen_fret_c = load_c ? dec_c.fret : string_fret;

    for (genvar s = 0; s < int'(NUM_STRINGS); s++) begin : g_tone
        tone_gen #(
            .STR(s)
        ) u_tone (
            .clk     (clk),
            .resetn  (resetn),
            .on      (string_on[s]),
            .restart (restart_c),
            .fret    (gen_fret_c[FRET_W*s +: FRET_W]),
            .tone    (tone[s])
        );
    end

endmodule

// File: tb/tb_note_player.sv
// Randomized self-checking bench for note_player against a note-level reference model.
module tb_note_player;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        beat;
    logic [5:0]  last_addr;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        playing;
    logic        done;
    logic [5:0]  string_on;
    logic [17:0] string_fret;
    logic [5:0]  tone;
    logic [2:0]  mix;

    logic [31:0] mem [64];
    int checks   = 0;
    int failures = 0;
    int rd_count = 0;

    note_player dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .beat        (beat),
        .last_addr   (last_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .playing     (playing),
        .done        (done),
        .string_on   (string_on),
        .string_fret (string_fret),
        .tone        (tone),
        .mix         (mix)
    );

    always #5 clk = ~clk;

    // Synchronous-read note RAM plus a read counter.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= mem[rd_addr];
            rd_count <= rd_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Equal-tempered half period from semitone offset relative to A2 = 110 Hz.
    function automatic int hp_model(input int s, input int f);
        int  offs [6] = '{0, 5, 10, 15, 19, 24};
        real freq;
        freq = 110.0 * (2.0 ** ((real'(offs[s] + f) - 5.0) / 12.0));
        return $rtoi(50.0e6 / (2.0 * freq) + 0.5);
    endfunction

    // Highest set fret per string wins; fret 0 only when no higher fret bit.
    task automatic model_decode(input logic [31:0] w, output logic [5:0] on, output logic [17:0] fr);
        bit found;
        on = '0;
        fr = '0;
        for (int s = 0; s < 6; s++) begin
            found = 1'b0;
            for (int f = 4; f >= 1; f--) begin
                if (!found && w[6*f + s]) begin
                    on[s]        = 1'b1;
                    fr[3*s +: 3] = 3'(f);
                    found        = 1'b1;
                end
            end
            if (!found && w[s]) on[s] = 1'b1;
        end
    endtask

    function automatic int ones(input logic [5:0] v);
        int n = 0;
        for (int i = 0; i < 6; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        int n0;
        start = 1'b0; stop = 1'b0; beat = 1'b0; last_addr = '0; rd_data = '0;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rd_en, rd_addr, playing, done, string_on, string_fret, tone, mix} !== 42'd0) begin
                $display("FAIL reset_outputs cycle %0d got %h want 0", i,
                         {rd_en, rd_addr, playing, done, string_on, string_fret, tone, mix});
                failures++;
            end
        end
        resetn = 1'b1;
        n0 = rd_count;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({rd_en, rd_addr, playing, done, string_on, string_fret, tone, mix} !== 42'd0) begin
                $display("FAIL idle_outputs cycle %0d got %h want 0", i,
                         {rd_en, rd_addr, playing, done, string_on, string_fret, tone, mix});
                failures++;
            end
        end
        checks++;
        if (rd_count - n0 !== 0) begin
            $display("FAIL idle_reads got %0d want 0", rd_count - n0);
            failures++;
        end
    endtask

    task automatic test_single_note();
        mem[0] = 32'h0000_0002;
        last_addr = 6'd0;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({rd_en, rd_addr, playing} !== {1'b1, 6'd0, 1'b1}) begin
            $display("FAIL single_fetch got en=%b addr=%0d play=%b want 1/0/1", rd_en, rd_addr, playing);
            failures++;
        end
        tick();
        checks++;
        if (rd_en !== 1'b0) begin
            $display("FAIL single_load_rd_en got %b want 0", rd_en);
            failures++;
        end
        tick();
        checks++;
        if ({string_on, string_fret} !== {6'b000010, 18'd0}) begin
            $display("FAIL single_hold got on=%b fret=%h want 000010/0", string_on, string_fret);
            failures++;
        end
        repeat (7) tick();
        beat = 1'b1; tick(); beat = 1'b0;
        checks++;
        if ({done, playing, string_on} !== {1'b1, 1'b0, 6'd0}) begin
            $display("FAIL single_done got done=%b play=%b on=%b want 1/0/0", done, playing, string_on);
            failures++;
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL single_done_pulse got %b want 0", done);
            failures++;
        end
    endtask

    // Plays mem[0..last]; inject adds a beat in FETCH and a start in HOLD, both to be ignored.
    task automatic run_play(input int last, input bit inject);
        logic [5:0]  eon;
        logic [17:0] efr;
        int gap;
        int n0;
        n0 = rd_count;
        last_addr = 6'(last);
        start = 1'b1; tick(); start = 1'b0;
        last_addr = 6'($urandom);
        for (int i = 0; i <= last; i++) begin
            checks++;
            if ({rd_en, rd_addr} !== {1'b1, 6'(i)}) begin
                $display("FAIL fetch[%0d] got en=%b addr=%0d want 1/%0d", i, rd_en, rd_addr, i);
                failures++;
            end
            if (inject) beat = 1'b1;
            tick(); beat = 1'b0;
            checks++;
            if (rd_en !== 1'b0) begin
                $display("FAIL rd_en_width[%0d] got %b want 0", i, rd_en);
                failures++;
            end
            tick();
            model_decode(mem[i], eon, efr);
            checks++;
            if ({string_on, string_fret, playing} !== {eon, efr, 1'b1}) begin
                $display("FAIL note[%0d] word %h got on=%b fret=%h play=%b want %b/%h/1",
                         i, mem[i], string_on, string_fret, playing, eon, efr);
                failures++;
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                if (inject && g == 0) start = 1'b1;
                tick(); start = 1'b0;
            end
            beat = 1'b1; tick(); beat = 1'b0;
        end
        checks++;
        if ({done, playing, string_on, tone} !== {1'b1, 1'b0, 6'd0, 6'd0}) begin
            $display("FAIL play_done last=%0d got done=%b play=%b on=%b tone=%b want 1/0/0/0",
                     last, done, playing, string_on, tone);
            failures++;
        end
        if (inject) beat = 1'b1;
        tick(); beat = 1'b0;
        checks++;
        if ({done, playing} !== 2'b00) begin
            $display("FAIL play_after_done got done=%b play=%b want 0/0", done, playing);
            failures++;
        end
        repeat (3) tick();
        checks++;
        if (rd_count - n0 !== last + 1) begin
            $display("FAIL read_count last=%0d got %0d want %0d", last, rd_count - n0, last + 1);
            failures++;
        end
    endtask

    task automatic test_decode();
        mem[0] = 32'h0100_0040;
        mem[1] = 32'hC000_0000;
        mem[2] = 32'h0000_0000;
        mem[3] = $urandom;
        run_play(3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) mem[i] = $urandom;
            run_play($urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        run_play(63, 1'b1);
        run_play($urandom_range(1, 10), 1'b1);
    endtask

    task automatic test_stop();
        for (int i = 0; i < 8; i++) mem[i] = $urandom | 32'h1;
        last_addr = 6'd7;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if ({rd_en, playing, done, string_on, tone} !== 15'd0) begin
            $display("FAIL stop_hold got en=%b play=%b done=%b on=%b tone=%b want 0",
                     rd_en, playing, done, string_on, tone);
            failures++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({done, rd_en, playing} !== 3'b000) begin
                $display("FAIL stop_quiet cycle %0d got done=%b en=%b play=%b want 0", i, done, rd_en, playing);
                failures++;
            end
        end
        start = 1'b1; tick(); start = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if ({rd_en, playing} !== 2'b00) begin
            $display("FAIL stop_fetch got en=%b play=%b want 0/0", rd_en, playing);
            failures++;
        end
        tick();
        checks++;
        if ({rd_en, string_on, playing} !== 8'd0) begin
            $display("FAIL stop_fetch_after got en=%b on=%b play=%b want 0", rd_en, string_on, playing);
            failures++;
        end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        checks++;
        if ({rd_en, playing} !== 2'b00) begin
            $display("FAIL start_stop_same got en=%b play=%b want 0/0", rd_en, playing);
            failures++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) mem[i] = $urandom | 32'h3F;
        last_addr = 6'd3;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        resetn = 1'b0; tick();
        checks++;
        if ({rd_en, rd_addr, playing, done, string_on, string_fret, tone, mix} !== 42'd0) begin
            $display("FAIL reset_mid got %h want 0", {rd_en, rd_addr, playing, done, string_on, string_fret, tone, mix});
            failures++;
        end
        resetn = 1'b1;
        repeat (2) tick();
        checks++;
        if ({rd_en, playing} !== 2'b00) begin
            $display("FAIL reset_mid_idle got en=%b play=%b want 0/0", rd_en, playing);
            failures++;
        end
        run_play(2, 1'b0);
    endtask

    // String 5 fret 4 has the shortest half period; every other string stays low in this window.
    task automatic test_tone();
        logic [5:0]  eon;
        logic [17:0] efr;
        logic [5:0]  exp_t, prev_t;
        int hp [6];
        int limit;
        mem[0] = $urandom | 32'h2000_0000;
        model_decode(mem[0], eon, efr);
        for (int s = 0; s < 6; s++) hp[s] = hp_model(s, int'(efr[3*s +: 3]));
        limit = hp[5] + 3;
        last_addr = 6'd0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        prev_t = '0;
        for (int c = 0; c <= limit; c++) begin
            for (int s = 0; s < 6; s++) exp_t[s] = eon[s] ? (((c / hp[s]) % 2) == 1) : 1'b0;
            checks++;
            if (tone !== exp_t) begin
                $display("FAIL tone cycle %0d after load got %b want %b", c, tone, exp_t);
                failures++;
                break;
            end
            if (c > 0) begin
                checks++;
                if (mix !== 3'(ones(prev_t))) begin
                    $display("FAIL mix cycle %0d after load got %0d want %0d", c, mix, ones(prev_t));
                    failures++;
                    break;
                end
            end
            prev_t = exp_t;
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if (tone !== 6'd0) begin
            $display("FAIL tone_after_stop got %b want 0", tone);
            failures++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_decode();
        test_sequence();
        test_stop();
        test_reset_mid();
        test_tone();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
